// File: rtl/commit_mem_fillctrl_pkg.sv
// Shared definitions for the commit-stage memory path: fill FSM states,
// line geometry and read-burst encodings.
package commit_mem_fillctrl_pkg;

    localparam int LINE_WORDS = 8;

    // Word index of a byte address inside a 32-byte line.
    localparam int LINE_OFF_HI = 4;
    localparam int LINE_OFF_LO = 2;

    localparam logic BURST_SINGLE = 1'b0;
    localparam logic BURST_WRAP   = 1'b1;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_AR,
        FILL_DATA
    } fill_state_e;

endpackage

// File: rtl/commit_mem_fillctrl.sv
// Miss-fill controller: turns one load-miss request into a single AR burst and
// streams the returned beats into the commit load buffer.
module commit_mem_fillctrl
    import commit_mem_fillctrl_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_uncached,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arlen,
    output logic        m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    output logic        wea,
    output logic [31:0] addra,
    output logic [31:0] dina,
    output logic        web,
    output logic [31:0] addrb,
    output logic [31:0] dinb,
    output logic        wec,
    output logic        fill_done,
    output logic        fill_err
);

    localparam logic [2:0]  LAST_BEAT = 3'(LINE_WORDS - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    fill_state_e r_state;
    fill_state_e w_next;

    logic [31:0] r_addr;
    logic [2:0]  r_arlen;
    logic        r_arburst;
    logic [2:0]  r_cnt;
    logic        r_rlastEarly;

    logic        r_wea;
    logic        r_web;
    logic        r_wec;
    logic [31:0] r_addra;
    logic [31:0] r_addrb;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_rHs;
    logic        w_lastBeat;
    logic        w_uncached;
    logic [2:0]  w_idx;

    assign w_accept   = req_ready & req_valid;
    assign w_rHs      = m_rready & m_rvalid;
    assign w_lastBeat = (r_cnt == r_arlen);
    assign w_uncached = (r_arburst == BURST_SINGLE);
    assign w_idx      = r_addr[LINE_OFF_HI:LINE_OFF_LO] + r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (r_state)
            FILL_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = FILL_AR;
            end
            FILL_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) w_next = FILL_DATA;
            end
            FILL_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid && w_lastBeat) w_next = FILL_IDLE;
            end
            default: w_next = FILL_IDLE;
        endcase
    end

    // Beat count alone ends the fill; rlast is only audited, with early
    // assertions remembered until the final beat reports them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_arlen      <= '0;
            r_arburst    <= BURST_SINGLE;
            r_cnt        <= '0;
            r_rlastEarly <= 1'b0;
            r_wea        <= 1'b0;
            r_web        <= 1'b0;
            r_wec        <= 1'b0;
            r_addra      <= '0;
            r_addrb      <= '0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wea  <= 1'b0;
            r_web  <= 1'b0;
            r_wec  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_addr       <= req_addr;
                r_arlen      <= req_uncached ? 3'd0 : LAST_BEAT;
                r_arburst    <= req_uncached ? BURST_SINGLE : BURST_WRAP;
                r_cnt        <= '0;
                r_rlastEarly <= 1'b0;
                r_wec        <= ~req_uncached;
            end
            if (w_rHs) begin
                r_cnt   <= r_cnt + 3'd1;
                r_wdata <= m_rdata;
                if (w_uncached) begin
                    r_wea   <= 1'b1;
                    r_addra <= r_addr & WORD_MASK;
                end else begin
                    r_web   <= 1'b1;
                    r_addrb <= {r_addr[31:LINE_OFF_HI+1], w_idx, 2'b00};
                end
                if (w_lastBeat) begin
                    r_done <= 1'b1;
                    r_err  <= ~m_rlast | r_rlastEarly;
                end else if (m_rlast) begin
                    r_rlastEarly <= 1'b1;
                end
            end
        end
    end

    assign m_araddr  = r_addr & WORD_MASK;
    assign m_arlen   = r_arlen;
    assign m_arburst = r_arburst;
    assign wea       = r_wea;
    assign addra     = r_addra;
    assign dina      = r_wdata;
    assign web       = r_web;
    assign addrb     = r_addrb;
    assign dinb      = r_wdata;
    assign wec       = r_wec;
    assign fill_done = r_done;
    assign fill_err  = r_err;

endmodule

// File: tb/tb_commit_mem_fillctrl.sv
// Directed bench for the miss-fill controller: a table of single fills plus
// hand-written backpressure, rlast-error, reset and back-to-back sequences.
module tb_commit_mem_fillctrl;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqUncached;
    logic        arValid;
    logic        arReady;
    logic [31:0] arAddr;
    logic [2:0]  arLen;
    logic        arBurst;
    logic        rValid;
    logic        rReady;
    logic [31:0] rData;
    logic        rLast;
    logic        weA;
    logic [31:0] addrA;
    logic [31:0] dinA;
    logic        weB;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic        weC;
    logic        fillDone;
    logic        fillErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        unc;
        logic [31:0] expAraddr;
        logic [2:0]  expArlen;
        logic        expBurst;
        logic [31:0] expFirstW;
        logic [31:0] expLastW;
    } fillVec_t;

    fillVec_t    vecs[5];
    logic [31:0] capAddr[8];
    logic [31:0] cwList[8];

    commit_mem_fillctrl #(.LINE_WORDS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .req_addr    (reqAddr),
        .req_uncached(reqUncached),
        .m_arvalid   (arValid),
        .m_arready   (arReady),
        .m_araddr    (arAddr),
        .m_arlen     (arLen),
        .m_arburst   (arBurst),
        .m_rvalid    (rValid),
        .m_rready    (rReady),
        .m_rdata     (rData),
        .m_rlast     (rLast),
        .wea         (weA),
        .addra       (addrA),
        .dina        (dinA),
        .web         (weB),
        .addrb       (addrB),
        .dinb        (dinB),
        .wec         (weC),
        .fill_done   (fillDone),
        .fill_err    (fillErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic unc);
        reqValid    = valid;
        reqAddr     = addr;
        reqUncached = unc;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".req_ready"}, 32'(reqReady), 32'd1);
        checkOutput({tag, ".arvalid"},   32'(arValid),  32'd0);
        checkOutput({tag, ".araddr"},    arAddr,        32'd0);
        checkOutput({tag, ".arlen"},     32'(arLen),    32'd0);
        checkOutput({tag, ".arburst"},   32'(arBurst),  32'd0);
        checkOutput({tag, ".rready"},    32'(rReady),   32'd0);
        checkOutput({tag, ".wea"},       32'(weA),      32'd0);
        checkOutput({tag, ".web"},       32'(weB),      32'd0);
        checkOutput({tag, ".wec"},       32'(weC),      32'd0);
        checkOutput({tag, ".addra"},     addrA,         32'd0);
        checkOutput({tag, ".addrb"},     addrB,         32'd0);
        checkOutput({tag, ".dina"},      dinA,          32'd0);
        checkOutput({tag, ".dinb"},      dinB,          32'd0);
        checkOutput({tag, ".fill_done"}, 32'(fillDone), 32'd0);
        checkOutput({tag, ".fill_err"},  32'(fillErr),  32'd0);
    endtask

    // Presents a request for one cycle; the accept edge is the tick.
    task automatic issueReq(input logic [31:0] addr, input logic unc);
        applyStimulus(1'b1, addr, unc);
        checkOutput("req.ready", 32'(reqReady), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    // Called in the cycle after accept; stalls arready for 'stall' cycles.
    task automatic arPhase(input logic unc, input logic [31:0] expAraddr, input logic [2:0] expArlen,
                           input logic expBurst, input int stall);
        checkOutput("ar.arvalid", 32'(arValid), 32'd1);
        checkOutput("ar.wec",     32'(weC),     32'(!unc));
        checkOutput("ar.araddr",  arAddr,       expAraddr);
        checkOutput("ar.arlen",   32'(arLen),   32'(expArlen));
        checkOutput("ar.arburst", 32'(arBurst), 32'(expBurst));
        checkOutput("ar.rready",  32'(rReady),  32'd0);
        for (int s = 0; s < stall; s++) begin
            arReady = 1'b0;
            tick();
            checkOutput("arstall.arvalid", 32'(arValid), 32'd1);
            checkOutput("arstall.araddr",  arAddr,       expAraddr);
            checkOutput("arstall.arlen",   32'(arLen),   32'(expArlen));
            checkOutput("arstall.arburst", 32'(arBurst), 32'(expBurst));
            checkOutput("arstall.wec",     32'(weC),     32'd0);
        end
        arReady = 1'b1;
        tick();
        arReady = 1'b0;
        checkOutput("ar.arvalid_off", 32'(arValid), 32'd0);
        checkOutput("ar.rready_on",   32'(rReady),  32'd1);
        checkOutput("ar.wec_off",     32'(weC),     32'd0);
    endtask

    // Feeds up to 'stopAfter' beats; errBeat<0 means a well-formed rlast.
    task automatic dataPhase(input logic [31:0] addr, input logic unc, input bit gaps, input int errBeat,
                             input int stopAfter, input logic [31:0] expFirst, input logic [31:0] expLast);
        int          nBeats;
        bit          fin;
        logic [31:0] dat;
        logic [31:0] expW;
        logic [31:0] gotW;
        logic [2:0]  idx;
        nBeats = unc ? 1 : 8;
        for (int k = 0; k < nBeats && k < stopAfter; k++) begin
            fin    = (k == nBeats - 1);
            dat    = 32'hDEAD_BEEF + 32'(k) * 32'h0101_0101;
            rValid = 1'b1;
            rData  = dat;
            rLast  = (errBeat < 0) ? fin : (k == errBeat);
            tick();
            idx  = addr[4:2] + 3'(k);
            expW = unc ? {addr[31:2], 2'b00} : {addr[31:5], idx, 2'b00};
            gotW = unc ? addrA : addrB;
            capAddr[k] = gotW;
            checkOutput("beat.wea",       32'(weA),      32'(unc));
            checkOutput("beat.web",       32'(weB),      32'(!unc));
            checkOutput("beat.addr",      gotW,          expW);
            checkOutput("beat.data",      unc ? dinA : dinB, dat);
            checkOutput("beat.fill_done", 32'(fillDone), 32'(fin));
            checkOutput("beat.fill_err",  32'(fillErr),  32'(fin && errBeat >= 0));
            checkOutput("beat.req_ready", 32'(reqReady), 32'(fin));
            checkOutput("beat.wec",       32'(weC),      32'd0);
            if (k == 0) checkOutput("beat.first_addr", gotW, expFirst);
            if (fin)    checkOutput("beat.last_addr",  gotW, expLast);
            rValid = 1'b0;
            rLast  = 1'b0;
            if (gaps && !fin) begin
                tick();
                checkOutput("gap.web",       32'(weB),      32'd0);
                checkOutput("gap.wea",       32'(weA),      32'd0);
                checkOutput("gap.fill_done", 32'(fillDone), 32'd0);
            end
        end
        rValid = 1'b0;
        rLast  = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".fill_done"}, 32'(fillDone), 32'd0);
        checkOutput({tag, ".web"},       32'(weB),      32'd0);
        checkOutput({tag, ".wea"},       32'(weA),      32'd0);
        checkOutput({tag, ".req_ready"}, 32'(reqReady), 32'd1);
    endtask

    // Reset state, the directed fill table, then the multi-cycle corner cases.
    initial begin
        vecs[0] = '{32'h1000_0006, 1'b1, 32'h1000_0004, 3'd0, 1'b0, 32'h1000_0004, 32'h1000_0004};
        vecs[1] = '{32'h2000_0014, 1'b0, 32'h2000_0014, 3'd7, 1'b1, 32'h2000_0014, 32'h2000_0010};
        vecs[2] = '{32'h3000_0000, 1'b0, 32'h3000_0000, 3'd7, 1'b1, 32'h3000_0000, 32'h3000_001C};
        vecs[3] = '{32'h4000_003F, 1'b0, 32'h4000_003C, 3'd7, 1'b1, 32'h4000_003C, 32'h4000_0038};
        vecs[4] = '{32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFF8, 3'd0, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        cwList  = '{32'h2000_0014, 32'h2000_0018, 32'h2000_001C, 32'h2000_0000,
                    32'h2000_0004, 32'h2000_0008, 32'h2000_000C, 32'h2000_0010};

        reset   = 1'b1;
        arReady = 1'b0;
        rValid  = 1'b0;
        rData   = 32'h0;
        rLast   = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkIdleOutputs("reset");
        reset = 1'b0;
        tick();

        $display("[TB] directed fill table");
        for (int v = 0; v < 5; v++) begin
            issueReq(vecs[v].addr, vecs[v].unc);
            arPhase(vecs[v].unc, vecs[v].expAraddr, vecs[v].expArlen, vecs[v].expBurst, 0);
            dataPhase(vecs[v].addr, vecs[v].unc, 1'b0, -1, 8, vecs[v].expFirstW, vecs[v].expLastW);
            tick();
            checkQuiet("table.after");
        end

        $display("[TB] backpressure on AR and R");
        issueReq(32'h2000_0014, 1'b0);
        arPhase(1'b0, 32'h2000_0014, 3'd7, 1'b1, 3);
        dataPhase(32'h2000_0014, 1'b0, 1'b1, -1, 8, 32'h2000_0014, 32'h2000_0010);
        for (int k = 0; k < 8; k++) checkOutput("cw.order", capAddr[k], cwList[k]);
        tick();
        checkQuiet("bp.after");

        $display("[TB] early rlast");
        issueReq(32'h6000_0008, 1'b0);
        arPhase(1'b0, 32'h6000_0008, 3'd7, 1'b1, 0);
        dataPhase(32'h6000_0008, 1'b0, 1'b0, 3, 8, 32'h6000_0008, 32'h6000_0004);
        tick();
        checkQuiet("err.after");
        checkOutput("err.fill_err_clear", 32'(fillErr), 32'd0);

        $display("[TB] reset mid-fill");
        issueReq(32'h5000_0008, 1'b0);
        arPhase(1'b0, 32'h5000_0008, 3'd7, 1'b1, 0);
        dataPhase(32'h5000_0008, 1'b0, 1'b0, -1, 4, 32'h5000_0008, 32'h0);
        reset = 1'b1;
        tick();
        checkIdleOutputs("midreset");
        reset = 1'b0;
        tick();
        issueReq(vecs[0].addr, vecs[0].unc);
        arPhase(1'b1, vecs[0].expAraddr, 3'd0, 1'b0, 0);
        dataPhase(vecs[0].addr, 1'b1, 1'b0, -1, 8, vecs[0].expFirstW, vecs[0].expLastW);
        tick();
        checkQuiet("postreset.after");

        $display("[TB] back-to-back cached requests");
        issueReq(32'h7000_0010, 1'b0);
        applyStimulus(1'b1, 32'h7100_001C, 1'b0);
        arPhase(1'b0, 32'h7000_0010, 3'd7, 1'b1, 1);
        dataPhase(32'h7000_0010, 1'b0, 1'b0, -1, 8, 32'h7000_0010, 32'h7000_000C);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("b2b.web_after_last", 32'(weB),      32'd0);
        checkOutput("b2b.wec_second",     32'(weC),      32'd1);
        checkOutput("b2b.fill_done_off",  32'(fillDone), 32'd0);
        arPhase(1'b0, 32'h7100_001C, 3'd7, 1'b1, 0);
        dataPhase(32'h7100_001C, 1'b0, 1'b0, -1, 8, 32'h7100_001C, 32'h7100_0018);
        tick();
        checkQuiet("b2b.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_mem_fillctrl.md
# commit_mem_fillctrl

Miss-fill controller for the commit-stage memory path. It accepts one load-miss request at a time and issues a single read on the memory read-address channel: one word for uncached requests, or an 8-word critical-word-first wrapping burst for cached ones. Returned beats are written into the downstream load buffer through its uncached port (`wea`/`addra`/`dina`) or its line port (`web`/`addrb`/`dinb`), and the buffered line is invalidated (`wec`) before each new cached fill. It sits directly upstream of the commit load buffer.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per line; fixed by the load buffer's `addr[4:2]` indexing.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  miss request valid.
- `req_ready`  out  1  controller idle; the request is accepted when `req_valid & req_ready`.
- `req_addr`  in  32  load byte address.
- `req_uncached`  in  1  1 = single-word uncached read.
- `m_arvalid`  out  1  read-address valid.
- `m_arready`  in  1  read-address ready.
- `m_araddr`  out  32  word-aligned start address.
- `m_arlen`  out  3  beats minus 1.
- `m_arburst`  out  1  1 = wrap within 32-byte line, 0 = single.
- `m_rvalid`  in  1  read-data valid.
- `m_rready`  out  1  read-data ready.
- `m_rdata`  in  32  read data.
- `m_rlast`  in  1  last beat flag.
- `wea`, `addra`, `dina`  out  1/32/32  uncached load-buffer write.
- `web`, `addrb`, `dinb`  out  1/32/32  line load-buffer write.
- `wec`  out  1  line load-buffer invalidate.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `fill_err`  out  1  valid with `fill_done`; `m_rlast` mismatch.

## Operation
- FSM states:
  - `IDLE`: `req_ready`=1. On accept, latch `addr`, `uncached`, `start=req_addr[4:2]`, clear beat counter, go to `AR`.
  - `AR`: `m_arvalid`=1. On `m_arready`, go to `DATA`.
  - `DATA`: `m_rready`=1. Each R handshake increments the 3-bit counter. Final beat (counter==`m_arlen`) returns to `IDLE`.
- AR fields:
  - Uncached: `m_araddr={addr[31:2],2'b00}`, `m_arlen`=0, `m_arburst`=0.
  - Cached: same `m_araddr`, `m_arlen`=7, `m_arburst`=1.
  - Fields are stable while `m_arvalid` is high.
- Cached beat k (k=0..7) has word index `(start+k) mod 8` (3-bit wrap). `addrb={addr[31:5], idx, 2'b00}`, `dinb=m_rdata`.
- Uncached beat: `addra={addr[31:2],2'b00}`, `dina=m_rdata`.
- `wec` pulses once per cached request only. Uncached fills never touch the line state.
- `fill_err`=1 if `m_rlast` is 0 on the final counted beat, or 1 on any earlier beat. Beat counting, not `m_rlast`, terminates the fill.
- A `req_valid` arriving while busy is held off (`req_ready`=0). The requester must hold it stable.

## Timing
- Reset values: all outputs 0 (`req_ready` is 1, since state is `IDLE`). Address and data outputs reset to 0.
- Accept at cycle T puts `m_arvalid` high at T+1. For a cached request, `wec` also pulses at T+1.
- `m_arvalid` deasserts in the cycle after the AR handshake. `m_rready` is high from that cycle onward.
- R handshake at cycle N produces the registered `web`/`wea` at N+1, with address and data. Writes are one per cycle while `m_rvalid` stays high.
- Final beat at N:
  - `fill_done` (and `fill_err`) pulse at N+1, coincident with the last write.
  - `req_ready` is 1 at N+1.
  - The earliest next `wec` is N+2, so it never collides with a `web`.
- `m_rvalid` gaps insert idle cycles. `web` is 0 in those cycles.
- Reset mid-fill: immediate return to `IDLE` and all pulses cleared. The memory side is reset with the same signal, so no stray beats are expected.

## Structure
- Shared commit-memory package holds:
  - FSM state encoding (`FILL_IDLE`, `FILL_AR`, `FILL_DATA`).
  - `LINE_WORDS`.
  - Burst encodings `BURST_SINGLE=0`, `BURST_WRAP=1`.
  - Line offset field `[4:2]`.
- Single flat module, no sub-module. The wrap index is a 3-bit adder inline.

## Test plan
- Uncached: `req_addr=0x1000_0006`, `uncached=1`.
  - Expect `araddr=0x1000_0004`, `arlen=0`, `arburst=0`.
  - Beat `0xDEAD_BEEF` with `rlast=1` gives `wea` with `addra=0x1000_0004`, `dina=0xDEAD_BEEF`, `fill_done` the same cycle, `fill_err`=0, and no `wec`.
- Cached critical-word: `req_addr=0x2000_0014`.
  - Expect `wec` at T+1, `araddr=0x2000_0014`, `arlen=7`.
  - Beats give `addrb` sequence `0x…14, 18, 1C, 00, 04, 08, 0C, 10` (prefix `0x2000_00`), one per cycle.
  - `fill_done` arrives with the 8th write.
- Backpressure: `m_arready` low for 3 cycles, then `m_rvalid` toggling 1,0,1,0.
  - AR fields stay stable.
  - `web` appears only on the cycles following handshakes, with the counter correct.
- Protocol error: `rlast` asserted on beat 3 of a cached fill.
  - All 8 beats are still consumed.
  - `fill_done` and `fill_err` both pulse at the end.
- Reset mid-fill: assert `reset` after 4 beats.
  - Next cycle, all outputs are 0 and `req_ready`=1.
  - A new uncached request then completes normally.
- Back-to-back: a second cached request held valid during the first fill.
  - It is accepted at N+1.
  - Its `wec` lands at N+2, after the final `web`.
